csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
Sequences every access to the CSR file and shares the single CSR port between two requesters: the core's Zicsr execute path (requester 0) and the debug module (requester 1). Each granted request runs as an atomic read-modify-write (CSRRW/CSRRS/CSRRC semantics) or a pure read. The block drives the CSR file's rd_en/explicit_rd/wr_en/addr/wr_data and returns read data, completion and an error flag to the requester. It sits between the decode/execute stage and the csr block.

Parameters:
DBG_PRIORITY, 0, 0 = round-robin between requesters; 1 = debug always wins when both request
ADDR_W, 12, CSR address width

Ports:
clk  in  1  global system clock
rst  in  1  synchronous reset, active-high
hold  in  1  trap/stall in progress; blocks acceptance of new requests
req  in  2  request per requester, [0]=core, [1]=debug; held until done
op_0, op_1  in  2 each  00=read, 01=RW, 10=RS (set), 11=RC (clear)
addr_0, addr_1  in  ADDR_W each  CSR address
wdata_0, wdata_1  in  32 each  write value / bit mask
done  out  2  one-cycle completion pulse per requester
err  out  1  valid with done: access was illegal
rdata  out  32  old CSR value, valid with done
busy  out  1  transaction in flight (state != IDLE)
csr_rd_en  out  1  CSR read enable
csr_explicit_rd  out  1  explicit read flag to CSR file
csr_wr_en  out  1  CSR write enable
csr_addr  out  ADDR_W  CSR address
csr_wr_data  out  32  CSR write data
csr_rd_data  in  32  CSR read data (combinational)
csr_illegal  in  1  CSR illegal address/permission (combinational)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; done=0, err=0, rdata=0, busy=0, all csr_* outputs 0; last_grant=1 (core wins first round-robin tie). Reset mid-transaction aborts it: no done pulse and no CSR write.
- FSM: IDLE -> READ -> (WRITE) -> RESP -> IDLE.
- IDLE: if hold=0 and req!=0, choose the winner and latch id, op, addr and wdata. Single request: that requester wins. Both requesting: debug if DBG_PRIORITY=1; otherwise the requester other than last_grant. last_grant updates on accept. Go to READ. With hold=1 or req=0, stay in IDLE.
- READ (1 cycle):
  - Drive csr_rd_en=1, csr_addr=latched addr.
  - Drive csr_explicit_rd=1 unless op=RW and the requester's rd-field-zero case applies; for simplicity csr_explicit_rd=1 for every op.
  - Capture old=csr_rd_data and ill=csr_illegal.
  - Write required when op=RW, or op=RS/RC with wdata!=0.
  - ill also set when a write is required and addr[11:10]==2'b11 (read-only space).
  - Next state is WRITE if a write is required and ill=0; otherwise RESP.
- WRITE (1 cycle): csr_wr_en=1, csr_addr=addr. csr_wr_data is wdata for RW, old|wdata for RS, old&~wdata for RC.
- RESP (1 cycle): done[id]=1, rdata=old, err=ill; go to IDLE. Clear rdata to 0 when err=1.
- Latency from accept edge to done: 2 cycles (no write), 3 cycles (write).
- Back-to-back: a request may be accepted in the IDLE cycle immediately after RESP, so there is 1 idle cycle minimum between transactions.
- After accept, changes to req, op, addr or wdata are ignored; the transaction always completes.
- hold asserted mid-transaction has no effect on the current transaction.
- csr_* outputs are 0 in IDLE and RESP, and are combinational from state plus latched registers.
- done, err and rdata are registered outputs.
- busy=1 in READ, WRITE and RESP.

Test Plan:
- Core RS, addr=0x340 (mscratch), old=0x0000_00F0, wdata=0x0F -> csr_rd_en 1 cycle, csr_wr_en with csr_wr_data=0x0000_00FF; done[0] 3 cycles after accept, rdata=0xF0, err=0.
- Core RC with wdata=0 on addr 0xC00 (cycle) -> no csr_wr_en, done[0] after 2 cycles, err=0; the same access as RW -> err=1, no write, rdata=0.
- Both req=2'b11 held continuously, DBG_PRIORITY=0 -> grants alternate core, debug, core, debug; with DBG_PRIORITY=1 -> debug every transaction.
- csr_illegal=1 during READ for an RW to 0x305 -> no csr_wr_en, done with err=1.
- hold=1 with req=01 -> stays IDLE, busy=0; after hold drops -> accepted next cycle.
- rst=1 asserted in WRITE state -> csr_wr_en=0 next cycle, no done pulse, state IDLE; core retry completes normally.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates core/debug CSR requests and runs each as an atomic read-modify-write.
module csr_access_ctrl #(
  parameter bit DBG_PRIORITY = 1'b0,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [1:0]        req,
  input  logic [1:0]        op_0,
  input  logic [1:0]        op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [31:0]       wdata_0,
  input  logic [31:0]       wdata_1,
  output logic [1:0]        done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              csr_rd_en,
  output logic              csr_explicit_rd,
  output logic              csr_wr_en,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wr_data,
  input  logic [31:0]       csr_rd_data,
  input  logic              csr_illegal
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0]        state_q, state_d, op_q, op_d, done_q, done_d;
  logic              id_q, id_d, last_q, last_d, ill_q, ill_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, old_q, old_d, rdata_q, rdata_d;
  logic              win, wr_need, ro_space;
  assign win      = &req ? (DBG_PRIORITY ? 1'b1 : ~last_q) : req[1];
  assign wr_need  = (op_q == 2'b01) | (op_q[1] & |wdata_q);
  assign ro_space = &addr_q[ADDR_W-1 -: 2];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    ill_d   = ill_q;
    done_d  = 2'b00;
    err_d   = 1'b0;
    rdata_d = 32'd0;
    case (state_q)
      IDLE: if (!hold && req != 2'b00) begin
        state_d = READ;
        id_d    = win;
        last_d  = win;
        op_d    = win ? op_1 : op_0;
        addr_d  = win ? addr_1 : addr_0;
        wdata_d = win ? wdata_1 : wdata_0;
      end
      READ: begin
        old_d   = csr_rd_data;
        ill_d   = csr_illegal | (wr_need & ro_space);
        state_d = (wr_need && !ill_d) ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      default: begin
        state_d     = IDLE;
        done_d[id_q] = 1'b1;
        err_d       = ill_q;
        rdata_d     = ill_q ? 32'd0 : old_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      ill_q   <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign done            = done_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign busy            = state_q != IDLE;
  assign csr_rd_en       = state_q == READ;
  assign csr_explicit_rd = state_q == READ;
  assign csr_wr_en       = state_q == WRITE;
  assign csr_addr        = (csr_rd_en | csr_wr_en) ? addr_q : '0;
  assign csr_wr_data     = !csr_wr_en ? 32'd0 :
                           op_q == 2'b01 ? wdata_q :
                           op_q == 2'b10 ? (old_q | wdata_q) : (old_q & ~wdata_q);
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed checks of arbitration, RMW sequencing, errors, hold and reset.
module tb_csr_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1, hold = 1'b0, csr_illegal = 1'b0;
  logic [1:0]  req = 2'b00, op_0 = 2'b00, op_1 = 2'b00;
  logic [11:0] addr_0 = '0, addr_1 = '0;
  logic [31:0] wdata_0 = '0, wdata_1 = '0, csr_rd_data = '0;
  logic [1:0]  done, p_done;
  logic        err, busy, csr_rd_en, csr_explicit_rd, csr_wr_en;
  logic        p_err, p_busy, p_rd_en, p_explicit_rd, p_wr_en;
  logic [31:0] rdata, csr_wr_data, p_rdata, p_wr_data;
  logic [11:0] csr_addr, p_addr;
  int          errors = 0, checks = 0;
  int          lat, nwr, nrd;
  logic [31:0] wrd, got_rdata;
  logic [11:0] wra;
  logic [1:0]  got_done;
  logic        got_err;
  logic [1:0]  seq0 [4];
  logic [1:0]  seq1 [4];

  always #5 clk = ~clk;

  csr_access_ctrl #(.DBG_PRIORITY(1'b0), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req(req), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .csr_rd_en(csr_rd_en),
    .csr_explicit_rd(csr_explicit_rd), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal));

  csr_access_ctrl #(.DBG_PRIORITY(1'b1), .ADDR_W(12)) dut_p (
    .clk(clk), .rst(rst), .hold(hold), .req(req), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .done(p_done), .err(p_err), .rdata(p_rdata), .busy(p_busy), .csr_rd_en(p_rd_en),
    .csr_explicit_rd(p_explicit_rd), .csr_wr_en(p_wr_en), .csr_addr(p_addr),
    .csr_wr_data(p_wr_data), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request from idle and observes the primary DUT until its done pulse.
  task automatic xact(input int r, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic il);
    op_0 = op; op_1 = op; addr_0 = a; addr_1 = a; wdata_0 = wd; wdata_1 = wd;
    csr_rd_data = rd; csr_illegal = il; req = 2'b01 << r;
    nwr = 0; nrd = 0; lat = -1; wrd = '0; wra = '0; got_done = '0; got_rdata = '0; got_err = 1'b0;
    for (int n = 0; n < 10 && lat < 0; n++) begin
      tick();
      if (csr_wr_en) begin nwr++; wrd = csr_wr_data; wra = csr_addr; end
      if (csr_rd_en && csr_explicit_rd && csr_addr == a) nrd++;
      if (done != 2'b00) begin
        lat = n; got_done = done; got_rdata = rdata; got_err = err;
      end
    end
    req = 2'b00;
    csr_illegal = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_csr", {csr_rd_en, csr_wr_en, csr_explicit_rd, csr_addr, 17'd0}, 32'd0);
    rst = 1'b0;
    tick();

    xact(0, 2'b10, 12'h340, 32'h0F, 32'hF0, 1'b0);
    check("rs_lat", lat, 3);
    check("rs_done", {30'd0, got_done}, 32'd1);
    check("rs_nrd", nrd, 1);
    check("rs_nwr", nwr, 1);
    check("rs_wdata", wrd, 32'hFF);
    check("rs_waddr", {20'd0, wra}, 32'h340);
    check("rs_rdata", got_rdata, 32'hF0);
    check("rs_err", {31'd0, got_err}, 32'd0);

    xact(0, 2'b11, 12'hC00, 32'h0, 32'h1234, 1'b0);
    check("rc0_lat", lat, 2);
    check("rc0_nwr", nwr, 0);
    check("rc0_err", {31'd0, got_err}, 32'd0);
    check("rc0_rdata", got_rdata, 32'h1234);

    xact(0, 2'b01, 12'hC00, 32'h5, 32'h1234, 1'b0);
    check("ro_lat", lat, 2);
    check("ro_nwr", nwr, 0);
    check("ro_err", {31'd0, got_err}, 32'd1);
    check("ro_rdata", got_rdata, 32'd0);

    xact(0, 2'b01, 12'h305, 32'h100, 32'h80, 1'b1);
    check("ill_nwr", nwr, 0);
    check("ill_err", {31'd0, got_err}, 32'd1);

    xact(0, 2'b11, 12'h300, 32'h0F, 32'hFF, 1'b0);
    check("rc_wdata", wrd, 32'hF0);
    check("rc_rdata", got_rdata, 32'hFF);

    xact(1, 2'b01, 12'h7B0, 32'hAA, 32'h55, 1'b0);
    check("dbg_done", {30'd0, got_done}, 32'd2);
    check("dbg_wdata", wrd, 32'hAA);
    check("dbg_rdata", got_rdata, 32'h55);

    xact(1, 2'b00, 12'h301, 32'hFFFF, 32'h4000_1104, 1'b0);
    check("rd_lat", lat, 2);
    check("rd_nwr", nwr, 0);
    check("rd_rdata", got_rdata, 32'h4000_1104);

    tick();
    hold = 1'b1; req = 2'b01; op_0 = 2'b00; addr_0 = 12'h340;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_busy", {31'd0, busy}, 32'd0);
    end
    hold = 1'b0;
    tick();
    check("hold_accept", {31'd0, busy}, 32'd1);
    hold = 1'b1;
    tick();
    tick();
    check("hold_mid_done", {30'd0, done}, 32'd1);
    req = 2'b00; hold = 1'b0;
    tick();

    xact(0, 2'b01, 12'h340, 32'h1, 32'h0, 1'b0);
    req = 2'b01; op_0 = 2'b01; addr_0 = 12'h340; wdata_0 = 32'h77;
    tick();
    tick();
    check("rstw_wr_en", {31'd0, csr_wr_en}, 32'd1);
    rst = 1'b1;
    tick();
    check("rstw_wr_off", {31'd0, csr_wr_en}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    req = 2'b00; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstw_nodone", {30'd0, done}, 32'd0);
    end
    xact(0, 2'b01, 12'h340, 32'h77, 32'h1, 1'b0);
    check("retry_lat", lat, 3);
    check("retry_wdata", wrd, 32'h77);
    check("retry_done", {30'd0, got_done}, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    op_0 = 2'b00; op_1 = 2'b00; csr_rd_data = 32'h9;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin seq0[k] = 2'b00; seq1[k] = 2'b00; end
    begin
      int c0, c1;
      c0 = 0; c1 = 0;
      for (int n = 0; n < 40 && (c0 < 4 || c1 < 4); n++) begin
        tick();
        if (done != 2'b00 && c0 < 4) begin seq0[c0] = done; c0++; end
        if (p_done != 2'b00 && c1 < 4) begin seq1[c1] = p_done; c1++; end
      end
      check("rr_count", c0, 4);
      check("pri_count", c1, 4);
    end
    req = 2'b00;
    check("rr_0", {30'd0, seq0[0]}, 32'd1);
    check("rr_1", {30'd0, seq0[1]}, 32'd2);
    check("rr_2", {30'd0, seq0[2]}, 32'd1);
    check("rr_3", {30'd0, seq0[3]}, 32'd2);
    for (int k = 0; k < 4; k++) check("pri_dbg", {30'd0, seq1[k]}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
